// File: rtl/mem_access_unit_if.sv
// Load/store bus between the MEM stage, the access unit and DataMemory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dm_address;
  logic [31:0] dm_data_in;
  logic [1:0]  dm_write;
  logic [1:0]  dm_data;
  logic [31:0] dm_data_out;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_fault;

  // Access unit side
  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, store_data, dm_data_out,
    output dm_address, dm_data_in, dm_write, dm_data, stall, load_data, load_valid,
           access_fault
  );

  // Pipeline / memory side
  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, store_data, dm_data_out,
    input  dm_address, dm_data_in, dm_write, dm_data, stall, load_data, load_valid,
           access_fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: decode, extension, misaligned byte splitting.
module mem_access_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_access_unit_if.slave   bus
);
  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_sdata, r_buf, r_load_data;
  logic        r_is_store, r_load_valid, r_fault;
  logic [2:0]  r_funct3;
  logic [1:0]  r_idx, r_last;

  logic        w_active, w_legal, w_misaligned;
  logic        w_latch, w_load_cap, w_split_done, w_buf_we, w_fault;
  logic [31:0] w_merged;
  logic [7:0]  w_store_byte;

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  f_extend = {{24{d[7]}}, d[7:0]};
      3'b001:  f_extend = {{16{d[15]}}, d[15:0]};
      3'b100:  f_extend = {24'd0, d[7:0]};
      3'b101:  f_extend = {16'd0, d[15:0]};
      default: f_extend = d;
    endcase
  endfunction

  assign w_active     = bus.req_valid & (bus.mem_read | bus.mem_write);
  assign w_misaligned = ((bus.funct3[1:0] == 2'b01) & bus.addr[0]) |
                        ((bus.funct3[1:0] == 2'b10) & (|bus.addr[1:0]));
  assign w_store_byte = 8'(r_sdata >> {r_idx, 3'b000});

  // Legal funct3 decode; store has priority over load
  always_comb begin
    w_legal = 1'b0;
    if (bus.mem_write) w_legal = (bus.funct3 == 3'b000) | (bus.funct3 == 3'b001) |
                                 (bus.funct3 == 3'b010);
    else               w_legal = (bus.funct3 == 3'b000) | (bus.funct3 == 3'b001) |
                                 (bus.funct3 == 3'b010) | (bus.funct3 == 3'b100) |
                                 (bus.funct3 == 3'b101);
  end

  // Split buffer with the current byte merged in at position idx
  always_comb begin
    w_merged = r_buf;
    case (r_idx)
      2'd0: w_merged[7:0]   = bus.dm_data_out[7:0];
      2'd1: w_merged[15:8]  = bus.dm_data_out[7:0];
      2'd2: w_merged[23:16] = bus.dm_data_out[7:0];
      default: w_merged[31:24] = bus.dm_data_out[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and DataMemory drive
  always_comb begin
    w_state_nxt    = r_state;
    bus.dm_address = 32'd0;
    bus.dm_data_in = 32'd0;
    bus.dm_write   = 2'b00;
    bus.dm_data    = 2'b00;
    bus.stall      = 1'b0;
    w_latch        = 1'b0;
    w_load_cap     = 1'b0;
    w_split_done   = 1'b0;
    w_buf_we       = 1'b0;
    w_fault        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active) begin
          if (!w_legal || (w_misaligned && !SPLIT_MISALIGNED)) begin
            w_fault = 1'b1;
          end else if (w_misaligned) begin
            bus.stall   = 1'b1;
            w_latch     = 1'b1;
            w_state_nxt = SPLIT;
          end else begin
            bus.dm_address = bus.addr;
            bus.dm_data_in = bus.store_data;
            bus.dm_data    = bus.funct3[1:0];
            if (bus.mem_write) bus.dm_write = 2'(bus.funct3[1:0]) + 2'd1;
            else               w_load_cap   = 1'b1;
          end
        end
      end
      SPLIT: begin
        bus.dm_address = r_addr + 32'(r_idx);
        if (r_is_store) begin
          bus.dm_write   = 2'b01;
          bus.dm_data_in = {24'd0, w_store_byte};
        end else begin
          w_buf_we = 1'b1;
        end
        bus.stall = (r_idx != r_last);
        if (r_idx == r_last) begin
          w_state_nxt  = IDLE;
          w_split_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset must silence memory writes and stall immediately
    if (!reset_n) begin
      bus.dm_write = 2'b00;
      bus.stall    = 1'b0;
    end
  end

  // Split context, buffer and registered load/fault results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= 32'd0;
      r_sdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_load_valid <= w_load_cap | (w_split_done & ~r_is_store);
      r_fault      <= w_fault;
      if (w_load_cap)
        r_load_data <= f_extend(bus.dm_data_out, bus.funct3);
      else if (w_split_done && !r_is_store)
        r_load_data <= f_extend(w_merged, r_funct3);
      if (w_latch) begin
        r_addr     <= bus.addr;
        r_sdata    <= bus.store_data;
        r_is_store <= bus.mem_write;
        r_funct3   <= bus.funct3;
        r_idx      <= 2'd0;
        r_last     <= (bus.funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
        r_buf      <= 32'd0;
      end else if (r_state == SPLIT) begin
        if (w_buf_we) r_buf <= w_merged;
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign bus.load_data    = r_load_data;
  assign bus.load_valid   = r_load_valid;
  assign bus.access_fault = r_fault;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-byte DataMemory model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  logic [7:0] mem [64];

  mem_access_unit_if b0();
  mem_access_unit_if b1();

  mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) u_split (.clk(clk), .reset_n(reset_n), .bus(b0));
  mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) u_nosplit (.clk(clk), .reset_n(reset_n), .bus(b1));

  always #5 clk = ~clk;

  // DataMemory model: combinational zero-extended read, write at the edge
  always_comb begin
    logic [5:0] a;
    a = b0.dm_address[5:0];
    case (b0.dm_data)
      2'b00:   b0.dm_data_out = {24'd0, mem[a]};
      2'b01:   b0.dm_data_out = {16'd0, mem[a + 6'd1], mem[a]};
      default: b0.dm_data_out = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    logic [5:0] a;
    a = b0.dm_address[5:0];
    if (b0.dm_write != 2'b00) mem[a] <= b0.dm_data_in[7:0];
    if (b0.dm_write[1]) mem[a + 6'd1] <= b0.dm_data_in[15:8];
    if (b0.dm_write == 2'b11) begin
      mem[a + 6'd2] <= b0.dm_data_in[23:16];
      mem[a + 6'd3] <= b0.dm_data_in[31:24];
    end
  end

  assign b1.dm_data_out = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    b0.req_valid = rd | wr; b0.mem_read = rd; b0.mem_write = wr;
    b0.funct3 = f3; b0.addr = a; b0.store_data = d;
  endtask

  task automatic idle();
    b0.req_valid = 1'b0; b0.mem_read = 1'b0; b0.mem_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    b1.req_valid = 1'b0; b1.mem_read = 1'b0; b1.mem_write = 1'b0;
    b1.funct3 = 3'd0; b1.addr = 32'd0; b1.store_data = 32'd0;
    drv(1'b0, 1'b1, 3'b010, 32'h0C, 32'h12345678);
    #2;
    chk("rst_dm_write", 32'(b0.dm_write), 32'd0);
    chk("rst_stall", 32'(b0.stall), 32'd0);
    chk("rst_load_valid", 32'(b0.load_valid), 32'd0);
    chk("rst_load_data", b0.load_data, 32'd0);
    chk("rst_fault", 32'(b0.access_fault), 32'd0);
    idle();
    tick(); tick();
    reset_n = 1'b1;

    // Aligned word store then load
    drv(1'b0, 1'b1, 3'b010, 32'h0C, 32'hDEADBEEF); #1;
    chk("sw_dm_write", 32'(b0.dm_write), 32'd3);
    chk("sw_stall", 32'(b0.stall), 32'd0);
    chk("sw_addr", b0.dm_address, 32'h0C);
    tick();
    chk("sw_no_lv", 32'(b0.load_valid), 32'd0);
    drv(1'b1, 1'b0, 3'b010, 32'h0C, 32'd0); #1;
    chk("lw_dm_write", 32'(b0.dm_write), 32'd0);
    chk("lw_dm_data", 32'(b0.dm_data), 32'd2);
    tick();
    chk("lw_valid", 32'(b0.load_valid), 32'd1);
    chk("lw_data", b0.load_data, 32'hDEADBEEF);
    idle(); tick();
    chk("idle_no_lv", 32'(b0.load_valid), 32'd0);
    chk("idle_hold", b0.load_data, 32'hDEADBEEF);

    // Byte and halfword extension
    drv(1'b0, 1'b1, 3'b000, 32'h04, 32'h123456AA); tick();
    drv(1'b1, 1'b0, 3'b000, 32'h04, 32'd0); tick();
    chk("lb", b0.load_data, 32'hFFFFFFAA);
    drv(1'b1, 1'b0, 3'b100, 32'h04, 32'd0); tick();
    chk("lbu", b0.load_data, 32'h000000AA);
    drv(1'b0, 1'b1, 3'b001, 32'h08, 32'h0000BEEF); #1;
    chk("sh_dm_write", 32'(b0.dm_write), 32'd2);
    tick();
    drv(1'b1, 1'b0, 3'b001, 32'h08, 32'd0); tick();
    chk("lh", b0.load_data, 32'hFFFFBEEF);
    drv(1'b1, 1'b0, 3'b101, 32'h08, 32'd0); tick();
    chk("lhu", b0.load_data, 32'h0000BEEF);
    chk("lhu_valid", 32'(b0.load_valid), 32'd1);

    // Misaligned word store split into four byte writes
    drv(1'b0, 1'b1, 3'b010, 32'h0D, 32'h11223344); #1;
    chk("msw_stall0", 32'(b0.stall), 32'd1);
    chk("msw_nowrite0", 32'(b0.dm_write), 32'd0);
    tick();
    chk("msw_lv_low", 32'(b0.load_valid), 32'd0);
    chk("msw_a0", b0.dm_address, 32'h0D);
    chk("msw_d0", {24'd0, b0.dm_data_in[7:0]}, 32'h44);
    chk("msw_w0", 32'(b0.dm_write), 32'd1);
    chk("msw_s1", 32'(b0.stall), 32'd1);
    tick();
    chk("msw_a1", b0.dm_address, 32'h0E);
    chk("msw_d1", {24'd0, b0.dm_data_in[7:0]}, 32'h33);
    chk("msw_s2", 32'(b0.stall), 32'd1);
    tick();
    chk("msw_d2", {24'd0, b0.dm_data_in[7:0]}, 32'h22);
    chk("msw_s3", 32'(b0.stall), 32'd1);
    tick();
    chk("msw_a3", b0.dm_address, 32'h10);
    chk("msw_d3", {24'd0, b0.dm_data_in[7:0]}, 32'h11);
    chk("msw_s4", 32'(b0.stall), 32'd0);
    drv(1'b1, 1'b0, 3'b010, 32'h0D, 32'd0); tick();
    chk("msw_no_lv", 32'(b0.load_valid), 32'd0);
    chk("msw_mem", {mem[6'h10], mem[6'h0F], mem[6'h0E], mem[6'h0D]}, 32'h11223344);

    // Misaligned word load, result after five cycles
    chk("mlw_stall0", 32'(b0.stall), 32'd1);
    tick(); chk("mlw_stall1", 32'(b0.stall), 32'd1);
    chk("mlw_dm_data", 32'(b0.dm_data), 32'd0);
    tick(); chk("mlw_stall2", 32'(b0.stall), 32'd1);
    tick(); chk("mlw_stall3", 32'(b0.stall), 32'd1);
    tick(); chk("mlw_stall4", 32'(b0.stall), 32'd0);
    chk("mlw_lv_early", 32'(b0.load_valid), 32'd0);
    idle(); tick();
    chk("mlw_valid", 32'(b0.load_valid), 32'd1);
    chk("mlw_data", b0.load_data, 32'h11223344);

    // Address wrap on a misaligned halfword load
    drv(1'b0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000034); tick();
    drv(1'b0, 1'b1, 3'b000, 32'h00000000, 32'h00000092); tick();
    drv(1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 32'd0); #1;
    chk("wrap_stall0", 32'(b0.stall), 32'd1);
    tick();
    chk("wrap_a0", b0.dm_address, 32'hFFFFFFFF);
    chk("wrap_stall1", 32'(b0.stall), 32'd1);
    tick();
    chk("wrap_a1", b0.dm_address, 32'h00000000);
    chk("wrap_stall2", 32'(b0.stall), 32'd0);
    idle(); tick();
    chk("wrap_valid", 32'(b0.load_valid), 32'd1);
    chk("wrap_data", b0.load_data, 32'hFFFF9234);

    // Illegal funct3 codes fault without accessing memory
    drv(1'b1, 1'b0, 3'b011, 32'h0C, 32'd0); #1;
    chk("ill_ld_write", 32'(b0.dm_write), 32'd0);
    tick();
    chk("ill_ld_fault", 32'(b0.access_fault), 32'd1);
    chk("ill_ld_no_lv", 32'(b0.load_valid), 32'd0);
    drv(1'b0, 1'b1, 3'b100, 32'h0C, 32'hFFFFFFFF); #1;
    chk("ill_st_write", 32'(b0.dm_write), 32'd0);
    tick();
    chk("ill_st_fault", 32'(b0.access_fault), 32'd1);
    idle(); tick();
    chk("fault_pulse_end", 32'(b0.access_fault), 32'd0);

    // Misaligned access without splitting is a fault
    b1.req_valid = 1'b1; b1.mem_read = 1'b1; b1.funct3 = 3'b010; b1.addr = 32'h02; #1;
    chk("ns_dm_write", 32'(b1.dm_write), 32'd0);
    chk("ns_stall", 32'(b1.stall), 32'd0);
    tick();
    chk("ns_fault", 32'(b1.access_fault), 32'd1);
    chk("ns_no_lv", 32'(b1.load_valid), 32'd0);
    b1.req_valid = 1'b0; b1.mem_read = 1'b0;

    // Reset in the middle of a split store
    drv(1'b0, 1'b1, 3'b010, 32'h20, 32'h55555555); tick();
    drv(1'b0, 1'b1, 3'b010, 32'h24, 32'h55555555); tick();
    drv(1'b0, 1'b1, 3'b010, 32'h21, 32'hCAFEBABE); tick();
    tick(); tick();
    chk("rs_idx2_addr", b0.dm_address, 32'h23);
    reset_n = 1'b0; #1;
    chk("rs_dm_write", 32'(b0.dm_write), 32'd0);
    chk("rs_stall", 32'(b0.stall), 32'd0);
    chk("rs_load_data", b0.load_data, 32'd0);
    chk("rs_load_valid", 32'(b0.load_valid), 32'd0);
    tick(); tick();
    idle();
    reset_n = 1'b1;
    tick();
    chk("rs_mem21", {24'd0, mem[6'h21]}, 32'hBE);
    chk("rs_mem22", {24'd0, mem[6'h22]}, 32'hBA);
    chk("rs_mem23", {24'd0, mem[6'h23]}, 32'h55);
    chk("rs_mem24", {24'd0, mem[6'h24]}, 32'h55);
    chk("rs_stall_after", 32'(b0.stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
